// File: rtl/conv_window_ctrl.sv
// Frame read controller for a KxK convolution window generator: reads N*N pixels, tags coordinates and legal window positions.
// Optional emitted-window counter is built when WINDOW_CTRL_COUNT_EN is defined.
module conv_window_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  input_dim,
  input  logic [1:0]            window_dim,
  input  logic                  stride,
  input  logic                  in_empty,
  input  logic [DATA_WIDTH-1:0] in_dout,
  output logic                  in_rd_en,
  input  logic                  out_full,
  output logic [DATA_WIDTH-1:0] win_data,
  output logic                  win_data_valid,
  output logic                  win_emit,
  output logic [DIM_WIDTH-1:0]  row,
  output logic [DIM_WIDTH-1:0]  col,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [15:0]           emit_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            r_state;
  logic [DIM_WIDTH-1:0]  r_n;
  logic [1:0]            r_k;
  logic                  r_s;
  logic [DIM_WIDTH-1:0]  r_rd_row, r_rd_col;
  logic                  r_vld, r_emit, r_cfg_err;
  logic [DIM_WIDTH-1:0]  r_row, r_col;
  logic [DATA_WIDTH-1:0] r_data;

  logic                  w_rd, w_last, w_bad, w_emit;
  logic [DIM_WIDTH-1:0]  w_kz, w_km1, w_nm1, w_dr, w_dc;

  assign w_kz  = {{(DIM_WIDTH-2){1'b0}}, window_dim};
  assign w_bad = (window_dim == 2'd0) || (input_dim < w_kz);
  assign w_km1 = {{(DIM_WIDTH-2){1'b0}}, r_k} - {{(DIM_WIDTH-1){1'b0}}, 1'b1};
  assign w_nm1 = r_n - {{(DIM_WIDTH-1){1'b0}}, 1'b1};
  assign w_dr  = r_rd_row - w_km1;
  assign w_dc  = r_rd_col - w_km1;

  assign w_rd   = (r_state == S_RUN) && !in_empty && !out_full;
  assign w_last = (r_rd_row == w_nm1) && (r_rd_col == w_nm1);
  // stride-2 keeps only even offsets from the first full window
  assign w_emit = (r_rd_row >= w_km1) && (r_rd_col >= w_km1) &&
                  (!r_s || (!w_dr[0] && !w_dc[0]));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_n       <= '0;
      r_k       <= '0;
      r_s       <= 1'b0;
      r_rd_row  <= '0;
      r_rd_col  <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          if (w_bad) begin
            r_cfg_err <= 1'b1;
          end else begin
            r_n      <= input_dim;
            r_k      <= window_dim;
            r_s      <= stride;
            r_rd_row <= '0;
            r_rd_col <= '0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: if (w_rd) begin
          if (w_last) begin
            r_state <= S_FLUSH;
          end else if (r_rd_col == w_nm1) begin
            r_rd_col <= '0;
            r_rd_row <= r_rd_row + 1'b1;
          end else begin
            r_rd_col <= r_rd_col + 1'b1;
          end
        end
        S_FLUSH: r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // FIFO data arrives the cycle after the read, so win_data passes in_dout
  // through while valid and replays the captured copy otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_vld  <= 1'b0;
      r_emit <= 1'b0;
      r_row  <= '0;
      r_col  <= '0;
      r_data <= '0;
    end else begin
      r_vld  <= w_rd;
      r_emit <= w_rd && w_emit;
      if (w_rd) begin
        r_row <= r_rd_row;
        r_col <= r_rd_col;
      end
      if (r_vld) r_data <= in_dout;
    end
  end

`ifdef WINDOW_CTRL_COUNT_EN
  logic [15:0] r_cnt;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE && start && !w_bad) begin
      r_cnt <= '0;
    end else if (r_emit && r_cnt != 16'hFFFF) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end
  assign emit_count = r_cnt;
`else
  assign emit_count = 16'd0;
`endif

  assign in_rd_en       = w_rd;
  assign win_data       = r_vld ? in_dout : r_data;
  assign win_data_valid = r_vld;
  assign win_emit       = r_emit;
  assign row            = r_row;
  assign col            = r_col;
  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);
  assign cfg_err        = r_cfg_err;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl: a frame-level model predicts every presented pixel,
// its coordinates and emit flag; literal emit positions pin the model.
module tb_conv_window_ctrl;
  logic        clock = 1'b0, reset = 1'b0, start = 1'b0;
  logic [7:0]  input_dim = '0;
  logic [1:0]  window_dim = '0;
  logic        stride = 1'b0, in_empty = 1'b1, out_full = 1'b0;
  logic [7:0]  in_dout = '0;
  logic        in_rd_en, win_data_valid, win_emit, busy, done, cfg_err;
  logic [7:0]  win_data, row, col;
  logic [15:0] emit_count;

  conv_window_ctrl #(.DATA_WIDTH(8), .DIM_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .start(start), .input_dim(input_dim),
    .window_dim(window_dim), .stride(stride), .in_empty(in_empty), .in_dout(in_dout),
    .in_rd_en(in_rd_en), .out_full(out_full), .win_data(win_data),
    .win_data_valid(win_data_valid), .win_emit(win_emit), .row(row), .col(col),
    .busy(busy), .done(done), .cfg_err(cfg_err), .emit_count(emit_count)
  );

  always #5 clock = ~clock;

  int pass_cnt = 0, tot_cnt = 0;
  task automatic chk(input string nm, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic [7:0] pix(input int i);
    return 8'(i * 37 + 11);
  endfunction

  // input FIFO model: data appears the cycle after each read
  logic fifo_clr = 1'b0;
  int   rd_idx = 0;
  always @(posedge clock) begin
    if (fifo_clr) rd_idx <= 0;
    else if (in_rd_en) begin
      in_dout <= pix(rd_idx);
      rd_idx  <= rd_idx + 1;
    end
  end

  // frame model
  int   m_n = 1, m_k = 1;
  bit   m_s = 0;
  int   exp_idx = 0, done_cnt = 0, n_emit = 0;
  int   emit_pos [16];
  bit   prev_rd = 0;
  int   last_data = 0, last_row = 0, last_col = 0;

  always @(negedge clock) begin
    int r, c, e;
    if (!reset) begin
      prev_rd = 0; last_data = 0; last_row = 0; last_col = 0;
    end else begin
      if (fifo_clr) begin exp_idx = 0; done_cnt = 0; n_emit = 0; end
      chk("rd_while_blocked", int'(in_rd_en & (in_empty | out_full)), 0);
      chk("valid_after_read", int'(win_data_valid), int'(prev_rd));
      if (win_data_valid) begin
        r = exp_idx / m_n;
        c = exp_idx % m_n;
        e = (r >= m_k - 1 && c >= m_k - 1 &&
             (!m_s || (((r - m_k + 1) % 2 == 0) && ((c - m_k + 1) % 2 == 0)))) ? 1 : 0;
        chk("row", int'(row), r);
        chk("col", int'(col), c);
        chk("data", int'(win_data), int'(pix(exp_idx)));
        chk("emit", int'(win_emit), e);
        if (win_emit && n_emit < 16) begin
          emit_pos[n_emit] = int'(row) * 16 + int'(col);
          n_emit++;
        end
        exp_idx++;
        last_data = int'(win_data); last_row = int'(row); last_col = int'(col);
      end else begin
        chk("emit_idle", int'(win_emit), 0);
        chk("data_hold", int'(win_data), last_data);
        chk("row_hold", int'(row), last_row);
        chk("col_hold", int'(col), last_col);
      end
      if (done) begin
        done_cnt++;
        chk("done_after_all", exp_idx, m_n * m_n);
      end
      prev_rd = in_rd_en;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, int'(in_rd_en), 0);
    chk({tag, "_valid"}, int'(win_data_valid), 0);
    chk({tag, "_emit"}, int'(win_emit), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_cfg_err"}, int'(cfg_err), 0);
    chk({tag, "_data"}, int'(win_data), 0);
    chk({tag, "_row"}, int'(row), 0);
    chk({tag, "_col"}, int'(col), 0);
    chk({tag, "_count"}, int'(emit_count), 0);
  endtask

  task automatic do_start(input int n, input int k, input bit s, input bit clr);
    @(posedge clock); #1;
    input_dim = 8'(n); window_dim = 2'(k); stride = s; start = 1'b1; fifo_clr = clr;
    if (clr) begin m_n = n; m_k = k; m_s = s; end
    @(posedge clock); #1;
    start = 1'b0; fifo_clr = 1'b0;
  endtask

  // mode 0: FIFO ready; 1: in_empty toggles, out_full high 3 cycles; 2: restart attempt mid-frame
  task automatic wait_done(input int mode);
    int cyc = 0;
    while (done_cnt == 0 && cyc < 300) begin
      in_empty = (mode == 1) && (cyc % 2 == 1);
      out_full = (mode == 1) && (cyc >= 10) && (cyc < 13);
      start    = (mode == 2) && (cyc == 5);
      if (mode == 2 && cyc == 5) input_dim = 8'd6;
      @(posedge clock); #1;
      cyc++;
    end
    in_empty = 1'b0; out_full = 1'b0; start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("done_pulse_count", done_cnt, 1);
  endtask

  task automatic run_frame(input int n, input int k, input bit s, input int mode,
                           input int p0, input int p1, input int p2, input int p3,
                           input int nv);
    do_start(n, k, s, 1'b1);
    chk("busy_after_start", int'(busy), 1);
    wait_done(mode);
    chk("n_emit", n_emit, 4);
    chk("emit_pos0", emit_pos[0], p0);
    chk("emit_pos1", emit_pos[1], p1);
    chk("emit_pos2", emit_pos[2], p2);
    chk("emit_pos3", emit_pos[3], p3);
    chk("n_valid", exp_idx, nv);
    chk("n_reads", rd_idx, nv);
    chk("busy_end", int'(busy), 0);
`ifdef WINDOW_CTRL_COUNT_EN
    chk("emit_count", int'(emit_count), 4);
`else
    chk("emit_count", int'(emit_count), 0);
`endif
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clock);
    #1;
    chk_zero("reset");
    reset = 1'b1; in_empty = 1'b0;

    run_frame(4, 3, 0, 0, 'h22, 'h23, 'h32, 'h33, 16);
    run_frame(5, 3, 1, 0, 'h22, 'h24, 'h42, 'h44, 25);
    run_frame(4, 3, 0, 1, 'h22, 'h23, 'h32, 'h33, 16);

    // rejected configurations
    base = rd_idx;
    do_start(4, 0, 0, 1'b0);
    chk("cfg_err_k0", int'(cfg_err), 1);
    chk("cfg_err_k0_busy", int'(busy), 0);
    @(posedge clock); #1;
    chk("cfg_err_pulse", int'(cfg_err), 0);
    do_start(2, 3, 0, 1'b0);
    chk("cfg_err_n_lt_k", int'(cfg_err), 1);
    chk("cfg_err_n_lt_k_busy", int'(busy), 0);
    repeat (3) @(posedge clock);
    #1;
    chk("cfg_err_no_reads", rd_idx, base);

    // reset mid-frame after 7 reads
    do_start(4, 3, 0, 1'b1);
    for (int i = 0; i < 50 && rd_idx < 7; i++) begin
      @(posedge clock); #1;
    end
    chk("reads_before_reset", rd_idx, 7);
    #1 reset = 1'b0;
    #1 chk_zero("midreset");
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 chk("no_done_after_reset", done_cnt, 0);
    run_frame(4, 3, 0, 0, 'h22, 'h23, 'h32, 'h33, 16);

    // start during RUN with another size must be ignored
    do_start(4, 3, 0, 1'b1);
    wait_done(2);
    chk("midstart_n_valid", exp_idx, 16);
    chk("midstart_n_emit", n_emit, 4);
    chk("midstart_last", emit_pos[3], 'h33);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
